// File: rtl/rgb565_gray_pipe.sv
// rgb565_gray_pipe: two-stage RGB565 to 8-bit gray converter with programmable weights and a delivered-pixel counter.
// Define GRAY_THRESHOLD_EN to add a runtime binary threshold on the gray output.
module rgb565_gray_pipe #(
    parameter int NUM_PIXELS  = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [7:0]              coeffRed,
    input  logic [7:0]              coeffGreen,
    input  logic [7:0]              coeffBlue,
`ifdef GRAY_THRESHOLD_EN
    input  logic [7:0]              thresholdValue,
    input  logic [0:0]              thresholdEnable,
`endif
    input  logic                    sValid,
    output logic                    sReady,
    input  logic [16*NUM_PIXELS-1:0] sData,
    output logic                    mValid,
    input  logic                    mReady,
    output logic [8*NUM_PIXELS-1:0] mData,
    output logic [COUNT_WIDTH-1:0]  pixelCount
);
    localparam int N = NUM_PIXELS;

    logic                  s1_valid, s1_ready, s2_ready;
    logic [N-1:0][15:0]    p_r, p_g, p_b;
    logic [N-1:0][7:0]     r8, g8, b8, clamped, gray;
    logic [N-1:0][9:0]     hi;

    assign s2_ready = !mValid || mReady;
    assign s1_ready = !s1_valid || s2_ready;
    assign sReady   = !reset && s1_ready;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            r8[i] = {sData[16*i+11 +: 5], sData[16*i+13 +: 3]};
            g8[i] = {sData[16*i+5 +: 6], sData[16*i+9 +: 2]};
            b8[i] = {sData[16*i +: 5], sData[16*i+2 +: 3]};
        end
    end

    // Max sum is 3*255*255, so the shifted result needs 10 bits before clamping.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            hi[i]      = 10'((18'(p_r[i]) + 18'(p_g[i]) + 18'(p_b[i])) >> 8);
            clamped[i] = |hi[i][9:8] ? 8'hFF : hi[i][7:0];
`ifdef GRAY_THRESHOLD_EN
            gray[i]    = thresholdEnable[0] ? ((clamped[i] >= thresholdValue) ? 8'hFF : 8'h00) : clamped[i];
`else
            gray[i]    = clamped[i];
`endif
        end
    end

    // Coefficients are captured together with the pixel so in-flight words keep their weights.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            p_r      <= '0;
            p_g      <= '0;
            p_b      <= '0;
        end else if (s1_ready) begin
            s1_valid <= sValid;
            if (sValid)
                for (int i = 0; i < N; i++) begin
                    p_r[i] <= 16'(r8[i]) * 16'(coeffRed);
                    p_g[i] <= 16'(g8[i]) * 16'(coeffGreen);
                    p_b[i] <= 16'(b8[i]) * 16'(coeffBlue);
                end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mValid <= 1'b0;
            mData  <= '0;
        end else if (s2_ready) begin
            mValid <= s1_valid;
            if (s1_valid)
                mData <= gray;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            pixelCount <= '0;
        else
            pixelCount <= clear ? '0 : (mValid && mReady) ? pixelCount + COUNT_WIDTH'(N) : pixelCount;
    end
endmodule

// File: tb/tb_rgb565_gray_pipe.sv
// tb_rgb565_gray_pipe: directed vectors with a queue scoreboard and an independent output monitor.
module tb_rgb565_gray_pipe;
    logic        clock = 1'b0, reset = 1'b1, clear = 1'b0;
    logic [7:0]  coeffRed = 8'd77, coeffGreen = 8'd150, coeffBlue = 8'd29;
    logic        sValid = 1'b0, mReady = 1'b1;
    logic [31:0] sData = '0;
    logic        sReady, mValid, s_ready4, m_valid4;
    logic [15:0] mData, pixelCount, m_data4;
    logic [3:0]  pc4;
`ifdef GRAY_THRESHOLD_EN
    logic [7:0]  thresholdValue = 8'd128;
    logic [0:0]  thresholdEnable = 1'b0;
`endif

    int          checks = 0, errs = 0;
    logic [15:0] exp_q[$];
    logic [15:0] cnt16 = '0;
    logic [3:0]  cnt4 = '0;
    logic        held = 1'b0;
    logic [15:0] held_d = '0;

    logic [31:0] vec_d[6] = '{32'h07E0_F800, 32'hFFFF_001F, 32'h0000_FFFF, 32'h0000_8410, 32'h07E0_001F, 32'hF800_0000};
    logic [15:0] vec_e[6] = '{16'h954C, 16'hFF1C, 16'h00FF, 16'h0082, 16'h951C, 16'h4C00};

    rgb565_gray_pipe dut (
        .clock(clock), .reset(reset), .clear(clear),
        .coeffRed(coeffRed), .coeffGreen(coeffGreen), .coeffBlue(coeffBlue),
`ifdef GRAY_THRESHOLD_EN
        .thresholdValue(thresholdValue), .thresholdEnable(thresholdEnable),
`endif
        .sValid(sValid), .sReady(sReady), .sData(sData),
        .mValid(mValid), .mReady(mReady), .mData(mData), .pixelCount(pixelCount)
    );

    rgb565_gray_pipe #(.NUM_PIXELS(2), .COUNT_WIDTH(4)) dut4 (
        .clock(clock), .reset(reset), .clear(clear),
        .coeffRed(coeffRed), .coeffGreen(coeffGreen), .coeffBlue(coeffBlue),
`ifdef GRAY_THRESHOLD_EN
        .thresholdValue(thresholdValue), .thresholdEnable(thresholdEnable),
`endif
        .sValid(sValid), .sReady(s_ready4), .sData(sData),
        .mValid(m_valid4), .mReady(mReady), .mData(m_data4), .pixelCount(pc4)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations on every output transfer, checks stall stability and both counters.
    always @(negedge clock) begin
        if (reset) begin
            held  = 1'b0;
            cnt16 = '0;
            cnt4  = '0;
        end else begin
            chk("pixel_count", 32'(pixelCount), 32'(cnt16));
            chk("pixel_count_w4", 32'(pc4), 32'(cnt4));
            if (held) begin
                chk("stall_valid", 32'(mValid), 32'd1);
                chk("stall_data", 32'(mData), 32'(held_d));
            end
            held   = mValid && !mReady;
            held_d = mData;
            if (mValid && mReady) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_output: got %h want none", mData);
                end else
                    chk("gray_data", 32'(mData), 32'(exp_q.pop_front()));
                cnt16 += 16'd2;
                cnt4  += 4'd2;
            end
            if (clear) begin
                cnt16 = '0;
                cnt4  = '0;
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [15:0] e);
        int  n = 0;
        logic ok = 1'b0;
        sValid = 1'b1;
        sData  = d;
        while (!ok && n < 50) begin
            @(negedge clock);
            ok = sReady;
            @(posedge clock);
            n++;
        end
        if (ok)
            exp_q.push_back(e);
        else begin
            checks++;
            errs++;
            $display("FAIL send_timeout: got sReady=0 want 1 within 50 cycles");
        end
        #1 sValid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clock);
            #1 n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errs++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clock);
        #1 clear = 1'b0;
    endtask

    initial begin
        #2;
        chk("reset_sready", 32'(sReady), 32'd0);
        chk("reset_mvalid", 32'(mValid), 32'd0);
        chk("reset_mdata", 32'(mData), 32'd0);
        chk("reset_count", 32'(pixelCount), 32'd0);
        #21 reset = 1'b0;
        @(posedge clock);
        #1 chk("sready_after_reset", 32'(sReady), 32'd1);

        send(32'h0000_FFFF, 16'h00FF);
        drain();
        chk("count_after_one", 32'(pixelCount), 32'd2);

        send(32'h07E0_F800, 16'h954C);
        send(32'hFFFF_001F, 16'hFF1C);
        drain();

        coeffRed = 8'd255; coeffGreen = 8'd255; coeffBlue = 8'd255;
        send(32'hFFFF_FFFF, 16'hFFFF);
        drain();
        coeffRed = 8'd77; coeffGreen = 8'd150; coeffBlue = 8'd29;

        send(32'h0000_F800, 16'h004C);
        coeffRed = 8'd0;
        send(32'h0000_F800, 16'h0000);
        drain();
        coeffRed = 8'd77;

        pulse_clear();
        chk("clear_alone", 32'(pixelCount), 32'd0);

        fork
            for (int i = 0; i < 6; i++) send(vec_d[i], vec_e[i]);
            begin
                repeat (2) @(posedge clock);
                #1 mReady = 1'b0;
                repeat (3) @(posedge clock);
                #1 chk("sready_full_stall", 32'(sReady), 32'd0);
                mReady = 1'b1;
            end
        join
        drain();
        chk("count_after_stream", 32'(pixelCount), 32'd12);

        pulse_clear();
        for (int i = 0; i < 9; i++) send(vec_d[i % 6], vec_e[i % 6]);
        drain();
        chk("count_w4_wrap", 32'(pc4), 32'd2);
        chk("count_after_nine", 32'(pixelCount), 32'd18);

        mReady = 1'b0;
        send(32'hFFFF_0000, 16'hFF00);
        for (int n = 0; n < 20 && !mValid; n++) @(posedge clock);
        #1 chk("valid_before_clear", 32'(mValid), 32'd1);
        clear  = 1'b1;
        mReady = 1'b1;
        @(posedge clock);
        #1 clear = 1'b0;
        chk("clear_wins", 32'(pixelCount), 32'd0);

        mReady = 1'b0;
        send(32'h07E0_F800, 16'h954C);
        send(32'hFFFF_001F, 16'hFF1C);
        chk("sready_two_held", 32'(sReady), 32'd0);
        #1 reset = 1'b1;
        #1;
        chk("midreset_mvalid", 32'(mValid), 32'd0);
        chk("midreset_mdata", 32'(mData), 32'd0);
        chk("midreset_sready", 32'(sReady), 32'd0);
        exp_q.delete();
        @(posedge clock);
        #3 reset = 1'b0;
        mReady = 1'b1;
        repeat (6) @(posedge clock);
        #1 chk("no_output_after_reset", 32'(mValid), 32'd0);
        chk("count_after_reset", 32'(pixelCount), 32'd0);
        send(32'h0000_8410, 16'h0082);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end
endmodule
